// File: rtl/uart_dump.sv
// uart_dump: reads word_num 32-bit words from instruction memory and streams them
// on uart_tx as 8N1 bytes, least-significant byte first, in the download format.

`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef UART_BPS
`define UART_BPS 115200
`endif
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef INST_DATA_BUS
`define INST_DATA_BUS 31:0
`endif

module delay_buffer #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], din};
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

module uart_dump #(
  parameter int BAUD_CNT_MAX = `CLK_FREQ / `UART_BPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump_en_i,
  input  logic [15:0]           word_num_i,
  output logic                  rib_rd_req_o,
  output logic                  mem_rd_en_o,
  output logic [`INST_ADDR_BUS] mem_rd_addr_o,
  input  logic [`INST_DATA_BUS] mem_rd_data_i,
  output logic                  uart_tx,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] STOP    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [12:0] BAUD_LAST = 13'(BAUD_CNT_MAX - 1);

  logic        en_s;
  logic        en_s_d;
  logic        start_evt;
  logic [2:0]  state;
  logic [12:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] word_num;
  logic [31:0] shift_word;
  logic        bit_end;
  logic [2:0]  next_bit;
  logic        more_words;

  delay_buffer #(.DEPTH(4)) u_en_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dump_en_i),
    .dout (en_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s_d <= 1'b0;
    end else begin
      en_s_d <= en_s;
    end
  end

  assign start_evt  = en_s & ~en_s_d;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign next_bit   = bit_cnt + 3'd1;
  assign more_words = (({1'b0, word_cnt} + 17'd1) < {1'b0, word_num});

  // Outputs are set on the transition into each state so every one is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      word_num      <= '0;
      shift_word    <= '0;
      mem_rd_addr_o <= '0;
      rib_rd_req_o  <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      uart_tx       <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else if (!en_s) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      word_cnt      <= '0;
      mem_rd_addr_o <= '0;
      rib_rd_req_o  <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      uart_tx       <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      rib_rd_req_o <= 1'b0;
      mem_rd_en_o  <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (start_evt) begin
            busy_o <= 1'b1;
            if (word_num_i != 16'd0) begin
              word_num      <= word_num_i;
              word_cnt      <= '0;
              mem_rd_addr_o <= '0;
              rib_rd_req_o  <= 1'b1;
              mem_rd_en_o   <= 1'b1;
              state         <= RD_REQ;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RD_REQ: begin
          baud_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          shift_word <= mem_rd_data_i;
          byte_cnt   <= '0;
          bit_cnt    <= '0;
          baud_cnt   <= '0;
          uart_tx    <= 1'b0;
          state      <= START;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shift_word[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 13'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= next_bit;
              uart_tx <= shift_word[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 13'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_cnt != 2'd3) begin
              shift_word <= shift_word >> 8;
              byte_cnt   <= byte_cnt + 2'd1;
              uart_tx    <= 1'b0;
              state      <= START;
            end else if (more_words) begin
              mem_rd_addr_o <= mem_rd_addr_o + 32'd4;
              word_cnt      <= word_cnt + 16'd1;
              rib_rd_req_o  <= 1'b1;
              mem_rd_en_o   <= 1'b1;
              state         <= RD_REQ;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end else begin
            baud_cnt <= baud_cnt + 13'd1;
          end
        end
        DONE: begin
          baud_cnt <= '0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dump.sv
// Scoreboarded bench for uart_dump: expected bytes/addresses are queued at
// stimulus time and independent monitors decode the serial line and bus.

module tb_uart_dump;

  localparam int BAUD = 16;

  logic        clk;
  logic        rst_n;
  logic        dump_en_i;
  logic [15:0] word_num_i;
  logic        rib_rd_req_o;
  logic        mem_rd_en_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic        uart_tx;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addrs[$];
  logic [31:0] mem[0:15];

  int     epoch    = 0;
  bit     hold     = 0;
  int     done_cnt = 0;
  int     rd_cnt   = 0;
  int     tx_low   = 0;
  longint cyc      = 0;
  int     last_ep  = -1;
  longint last_start = 0;
  int     byte_idx = 0;

  uart_dump #(.BAUD_CNT_MAX(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_en_i    (dump_en_i),
    .word_num_i   (word_num_i),
    .rib_rd_req_o (rib_rd_req_o),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_rd_addr_o(mem_rd_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .uart_tx      (uart_tx),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory answers one cycle after the strobe; other cycles return junk.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o[5:2]];
    else             mem_rd_data_i <= $urandom;
  end

  task automatic check_output(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: event occurred, required none", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_rd_en_o) begin
      rd_cnt++;
      check_output("rib_req_with_rd", rib_rd_req_o, 1);
      if (exp_addrs.size() == 0) report_fail("unexpected_read");
      else check_output("read_addr", mem_rd_addr_o, exp_addrs.pop_front());
    end
    if (rst_n && !uart_tx) tx_low++;
    if (done_o) begin
      done_cnt++;
      check_output("busy_during_done", busy_o, 1);
    end
  end

  task automatic run_frame();
    int my_ep = epoch;
    logic [7:0] want = 8'h00;
    logic [7:0] got = 8'h00;
    logic [9:0] pattern;
    bit have;
    bit glitch = 0;
    bit aborted = 0;
    if (my_ep == last_ep && byte_idx > 0)
      check_output("frame_gap", cyc - last_start, (byte_idx % 4 == 0) ? 2 + 10 * BAUD : 10 * BAUD);
    if (my_ep != last_ep) byte_idx = 0;
    last_ep = my_ep;
    last_start = cyc;
    byte_idx++;
    have = (exp_bytes.size() > 0);
    if (have) want = exp_bytes.pop_front();
    else report_fail("unexpected_frame");
    pattern = {1'b1, want, 1'b0};
    for (int k = 0; k < 10 * BAUD; k++) begin
      if (k > 0) @(negedge clk);
      if (epoch != my_ep || !rst_n) begin
        aborted = 1;
        break;
      end
      if (uart_tx !== pattern[k / BAUD]) glitch = 1;
      if (k % BAUD == BAUD / 2 && k / BAUD >= 1 && k / BAUD <= 8) got[k / BAUD - 1] = uart_tx;
    end
    if (!aborted && have) begin
      total++;
      if (glitch || got !== want) begin
        bad++;
        $display("[TB] FAIL frame: got %02h (bit timing bad=%0d) want %02h", got, glitch, want);
      end
    end
  endtask

  initial begin : frame_monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!hold && rst_n && prev && !uart_tx) run_frame();
      prev = uart_tx;
    end
  end

  task automatic push_expected(input int n);
    for (int w = 0; w < n; w++) begin
      exp_addrs.push_back(32'(4 * w));
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(mem[w] >> (8 * b)));
    end
  endtask

  task automatic apply_stimulus(input int n);
    int d0, r0, t0, cnt, budget;
    bit seen;
    @(posedge clk);
    #1;
    epoch++;
    push_expected(n);
    word_num_i = 16'(n);
    d0 = done_cnt;
    r0 = rd_cnt;
    t0 = tx_low;
    dump_en_i = 1'b1;
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 12) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (mem_rd_en_o || done_o) seen = 1;
    end
    check_output("start_latency", cnt, 5);
    check_output("busy_at_start", busy_o, 1);
    budget = 50 + n * (2 + 40 * BAUD);
    cnt = 0;
    while (done_cnt == d0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check_output("done_pulses", done_cnt - d0, 1);
    @(negedge clk);
    check_output("busy_after_done", busy_o, 0);
    check_output("read_count", rd_cnt - r0, n);
    check_output("bytes_left", exp_bytes.size(), 0);
    check_output("addrs_left", exp_addrs.size(), 0);
    if (n == 0) check_output("zero_tx_low_cycles", tx_low - t0, 0);
    exp_bytes.delete();
    exp_addrs.delete();
    dump_en_i = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_first_fall();
    int cnt = 0;
    while (uart_tx && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (uart_tx) report_fail("start_bit_timeout");
  endtask

  task automatic abort_test();
    int d0;
    mem[0] = 32'h12345678;
    mem[1] = $urandom;
    @(posedge clk);
    #1;
    epoch++;
    push_expected(2);
    word_num_i = 16'd2;
    dump_en_i = 1'b1;
    wait_first_fall();
    repeat (10 * BAUD + BAUD + 4) @(negedge clk);
    @(posedge clk);
    #1;
    hold = 1;
    epoch++;
    d0 = done_cnt;
    dump_en_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_output("abort_tx_idle", uart_tx, 1);
    check_output("abort_busy", busy_o, 0);
    check_output("abort_addr", mem_rd_addr_o, 0);
    repeat (30) @(negedge clk);
    check_output("abort_no_done", done_cnt - d0, 0);
    exp_bytes.delete();
    exp_addrs.delete();
    hold = 0;
    apply_stimulus(1);
  endtask

  task automatic reset_test();
    int r0, t0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(posedge clk);
    #1;
    epoch++;
    push_expected(1);
    word_num_i = 16'd1;
    dump_en_i = 1'b1;
    wait_first_fall();
    repeat (9 * BAUD + 6) @(negedge clk);
    #2;
    hold = 1;
    epoch++;
    rst_n = 1'b0;
    #1;
    check_output("rst_tx", uart_tx, 1);
    check_output("rst_busy", busy_o, 0);
    check_output("rst_rd_en", mem_rd_en_o, 0);
    check_output("rst_req", rib_rd_req_o, 0);
    check_output("rst_done", done_o, 0);
    dump_en_i = 1'b0;
    exp_bytes.delete();
    exp_addrs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_cnt;
    t0 = tx_low;
    repeat (40) @(negedge clk);
    check_output("post_rst_reads", rd_cnt - r0, 0);
    check_output("post_rst_tx_low", tx_low - t0, 0);
    check_output("post_rst_busy", busy_o, 0);
    hold = 0;
    apply_stimulus(2);
  endtask

  initial begin
    rst_n = 1'b0;
    dump_en_i = 1'b0;
    word_num_i = 16'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tx", uart_tx, 1);
    check_output("reset_busy", busy_o, 0);
    check_output("reset_done", done_o, 0);
    check_output("reset_rd_en", mem_rd_en_o, 0);
    check_output("reset_req", rib_rd_req_o, 0);
    check_output("reset_addr", mem_rd_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] single word");
    mem[0] = 32'h12345678;
    apply_stimulus(1);

    $display("[TB] three words");
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h00000000;
    mem[2] = 32'hFFFFFFFF;
    apply_stimulus(3);

    $display("[TB] zero count");
    apply_stimulus(0);

    $display("[TB] random dumps");
    repeat (4) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      apply_stimulus(int'($urandom_range(1, 4)));
    end

    $display("[TB] abort and restart");
    abort_test();

    $display("[TB] reset mid-dump");
    reset_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
